// File: rtl/wb_arbiter.sv
// wb_arbiter: fixed-priority write-back arbiter (ALU > LD > MUL > DIV) with a registered write port.
// Starvation aging is built only when WB_ARB_STARVE_EN is defined.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    input  logic [15:0]  req_rd,
    input  logic [127:0] req_data,
    input  logic         wb_stall,
    output logic [3:0]   req_ready,
    output logic         wr_ena,
    output logic [3:0]   wr_rd,
    output logic [31:0]  wr_data,
    output logic [3:0]   wr_src,
    output logic [3:0]   starve_flag
);
    logic [3:0]  starve, starved_v, grant;
    logic [3:0]  sel_rd;
    logic [31:0] sel_data;
    logic        wr_ena_q;
    logic [3:0]  wr_rd_q, wr_src_q;
    logic [31:0] wr_data_q;

    function automatic logic [3:0] pick(input logic [3:0] v);
        return v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : v[0] ? 4'b0001 : 4'b0000;
    endfunction

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be 1..15");
    end

`ifdef WB_ARB_STARVE_EN
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    for (genvar i = 0; i < 4; i++) begin : g_age
        logic [3:0] age_q, age_d;
        assign starve[i] = age_q == LIM;
        // Stalled cycles count as denials, so aging continues under wb_stall.
        assign age_d = (!req_valid[i] || grant[i]) ? 4'd0 : starve[i] ? age_q : age_q + 4'd1;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) age_q <= 4'd0;
            else        age_q <= age_d;
        end
    end
`else
    assign starve = 4'b0000;
`endif

    assign starved_v = starve & req_valid;
    assign grant     = (wb_stall || !rst_n) ? 4'b0000 : (|starved_v) ? pick(starved_v) : pick(req_valid);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int k = 0; k < 4; k++) begin
            sel_rd   = sel_rd | ({4{grant[k]}} & req_rd[k*4 +: 4]);
            sel_data = sel_data | ({32{grant[k]}} & req_data[k*32 +: 32]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ena_q  <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
        end else begin
            wr_ena_q <= |grant;
            wr_src_q <= grant;
            if (|grant) begin
                wr_rd_q   <= sel_rd;
                wr_data_q <= sel_data;
            end
        end
    end

    assign req_ready   = grant;
    assign wr_ena      = wr_ena_q;
    assign wr_rd       = wr_rd_q;
    assign wr_data     = wr_data_q;
    assign wr_src      = wr_src_q;
    assign starve_flag = starve;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbitrates the single register-file write port among the four execution units (ALU, LD, MUL, DIV) at the EXE/WB boundary. Each unit presents a valid/ready request carrying a destination register and a result. One request is granted per cycle and registered onto the write port. Fixed priority with optional starvation aging keeps long-latency units from being locked out by back-to-back ALU traffic.

## Interface
- STARVE_LIMIT, 4, denied-cycle count at which a waiting requester is promoted; legal range 1..15
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  4  request valid per unit; bit 3=ALU, 2=LD, 1=MUL, 0=DIV
- req_rd  in  16  destination registers, packed {alu,ld,mul,div}, 4 bits each
- req_data  in  128  results, packed {alu,ld,mul,div}, 32 bits each
- wb_stall  in  1  write port unavailable this cycle; no grant
- req_ready  out  4  combinational grant, one-hot or zero
- wr_ena  out  1  register-file write enable
- wr_rd  out  4  register-file write address
- wr_data  out  32  register-file write data
- wr_src  out  4  one-hot source of the current write; for forwarding and debug
- starve_flag  out  4  per-unit, age == STARVE_LIMIT

## Operation
- Transfer on unit i happens at a posedge where req_valid[i] & req_ready[i].
- A unit holds req_valid, req_rd and req_data stable until the transfer.
- Grant selection, combinational:
  - wb_stall=1 or rst_n=0: req_ready=0.
  - Any starve_flag set: grant the highest-index starved unit that is valid.
  - Otherwise: grant the highest-index valid unit (ALU > LD > MUL > DIV).
- Age counter per unit, width 4:
  - Increments on valid & ~ready, saturating at STARVE_LIMIT.
  - Cleared to 0 on transfer, or when req_valid=0.
  - Increments while wb_stall=1.
- Write port register on each posedge:
  - With a grant: wr_ena=1; wr_rd, wr_data, wr_src take the granted unit's values.
  - Without a grant: wr_ena=0, wr_src=0; wr_rd and wr_data hold their previous values.
- Writes to r0 are passed through unchanged; the register file decides what to do with them.

## Timing
- Reset, asynchronous and immediate: wr_ena=0, wr_rd=0, wr_data=0, wr_src=0, all ages=0, starve_flag=0, req_ready=0.
- Latency: a transfer at posedge N gives wr_ena=1 with its data in cycle N..N+1. Throughput is one write per cycle.
- Simultaneous valid requests: exactly one is granted; the others see ready=0 and age.
- When several units are starved together, the higher index wins; the losers stay saturated and win in later cycles.
- wb_stall asserted mid-burst: no transfer that cycle; the next cycle shows wr_ena=0.
- rst_n falling mid-operation: pending requests are not transferred, the write port clears at once, and units must re-present after reset.
- STARVE_LIMIT=1: any unit denied once has top priority in the next cycle.

## Configuration
- WB_ARB_STARVE_EN defined:
  - Aging logic is built as described.
- WB_ARB_STARVE_EN undefined:
  - Age counters are removed and starve_flag is tied to 0.
  - Pure fixed priority ALU > LD > MUL > DIV.
  - STARVE_LIMIT is ignored.

## Test plan
- Reset check: assert rst_n=0 mid-cycle with requests valid. Required: all outputs 0 immediately; no write after release until a new transfer.
- Single request: DIV valid, rd=5, data=0xDEADBEEF, other units idle. Required: req_ready=4'b0001 in the same cycle; next cycle wr_ena=1, wr_rd=5, wr_data=0xDEADBEEF, wr_src=4'b0001.
- Simultaneous requests: all four valid at once, each dropping after its transfer, STARVE_LIMIT=15. Required: writes in consecutive cycles in the order ALU, LD, MUL, DIV, with wr_src 8, 4, 2, 1.
- Starvation, WB_ARB_STARVE_EN defined, STARVE_LIMIT=4: ALU valid every cycle, DIV valid from cycle 0. Required: DIV denied in cycles 0–3; starve_flag[0]=1 and DIV granted in cycle 4; wr_src=4'b0001 in cycle 5; ALU resumes in cycle 5.
- Stall: wb_stall=1 for 3 cycles with ALU and MUL valid. Required: req_ready=0 and wr_ena=0; MUL age reaches 3. After release, ALU is written first, then MUL.
- Macro off: same stimulus as the starvation case for 20 cycles. Required: DIV is never granted and starve_flag stays 0.
